adc_serial_stream_gen: RTL and testbench
========================================

Name: adc_serial_stream_gen

Overview:
- Parametrised multi-channel serial ADC stream generator for FMC ADC simulation benches and on-chip self-test.
- Produces a frame clock plus one MSB-first serial data lane per channel, one bit per clock.
- Supports ramp, constant, alternating and externally supplied sample modes.
- Replaces free-running single-channel DCO/FR stimulus: channel count, sample width and frame length are configurable; start/stop and mode changes are frame-aligned.

Parameters:
g_NUM_CH, 4, number of channels/serial lanes (1..8)
g_SAMPLE_WIDTH, 14, sample bits per channel (1..g_BITS_PER_FRAME)
g_BITS_PER_FRAME, 16, clock cycles per frame; must be even, >= 4
g_RAMP_STEP_CH, 256, ramp offset between adjacent channels, modulo 2^g_SAMPLE_WIDTH

Ports:
clk_i  in  1  bit clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  run request
mode_i  in  2  0 ramp, 1 constant, 2 alternating, 3 external
pattern_i  in  g_SAMPLE_WIDTH  constant/alternating pattern
ext_data_i  in  g_NUM_CH*g_SAMPLE_WIDTH  external samples; channel n at bits [n*W +: W]
ext_valid_i  in  1  external sample valid
ext_ready_o  out  1  external sample accept strobe
fr_o  out  1  frame clock
data_o  out  g_NUM_CH  serial data, bit n = channel n
busy_o  out  1  frame in progress
frame_cnt_o  out  32  frames emitted
underflow_cnt_o  out  16  external-mode underflows

Behaviour:
- Reset (async assert, sync deassert internal): all outputs 0; bit_cnt=0; ramp base=0; last external sample=0; state IDLE.
- States: IDLE, RUN.
- Define F=g_BITS_PER_FRAME, W=g_SAMPLE_WIDTH.
- A load cycle occurs when in IDLE with enable_i=1, or in RUN with bit_cnt=F-1.
- At a load cycle:
  - enable_i=1: go or stay RUN; mode_i and pattern_i are sampled; the next sample set is latched into per-channel shift registers.
  - enable_i=0 (RUN only): go to IDLE.
- Transition latency: the cycle after the load cycle shows bit_cnt=0 with the sample MSB on data_o. The first frame starts exactly 1 cycle after enable_i is seen in IDLE.
- RUN outputs:
  - bit_cnt counts 0..F-1 and wraps.
  - fr_o=1 when bit_cnt<F/2, else 0.
  - data_o[n] = sample bit W-1-bit_cnt for bit_cnt<W; 0 for bit_cnt>=W (LSB zero padding).
  - busy_o=1.
- IDLE outputs: fr_o=0, data_o=0, busy_o=0.
- Stop is frame-aligned: deasserting enable_i mid-frame completes the current frame.
- Changes to mode_i/pattern_i mid-frame are ignored until the next load cycle.
- Sample generation at a load cycle:
  - Mode 0: channel n = (base + n*g_RAMP_STEP_CH) mod 2^W; base increments by 1 (wraps) after each mode-0 load; base persists across stops and resets only on rst_n_i.
  - Mode 1: all channels = pattern_i.
  - Mode 2: all channels alternate between pattern_i and ~pattern_i. The phase flag toggles on each mode-2 load and starts at pattern_i on the first mode-2 frame after any other mode or IDLE.
  - Mode 3: ext_ready_o=1 for exactly that cycle.
    - ext_valid_i=1: ext_data_i is latched and stored as the last external sample.
    - ext_valid_i=0: the last external sample is repeated and underflow_cnt_o increments, saturating at 16'hFFFF.
    - ext_ready_o is never asserted outside mode-3 load cycles.
- frame_cnt_o increments by 1 on each load cycle that starts a frame; wraps at 2^32; cleared only by reset.
- Reset asserted mid-frame: outputs go to 0 immediately; after release, the block restarts from IDLE with a fresh frame at bit_cnt=0.
- Single clock domain; no internal buffering beyond one sample set per channel.

Test Plan:
- Defaults, mode 1, pattern 14'h2A5B, enable held -> every lane shows 1010100101101100 per frame; fr_o high 8 cycles, low 8; frame_cnt_o=1 after first load.
- Mode 0, 3 frames -> frame k (0-based from reset) channel 0 = k and channel 3 = 768+k; after 16384 frames channel 0 wraps back to 0.
- Mode 2, pattern 14'h3FFF -> alternating frames of 16'hFFFC and 16'h0000 on all lanes; switching to mode 1 and back to mode 2 restarts the sequence with 16'hFFFC.
- Mode 3, valid held high at loads 1 and 2 only (data 14'h0001, then 14'h1234) -> the third frame repeats 14'h1234; underflow_cnt_o=1; ext_ready_o pulses once per frame, aligned with bit_cnt=F-1.
- enable_i dropped at bit 5 of a frame -> frame completes 11 more cycles; then fr_o=0, busy_o=0; re-assert -> MSB appears on data_o the next cycle.
- rst_n_i asserted at bit 9 -> all outputs 0 asynchronously; frame_cnt_o=0; ramp restarts at 0 after release.

Source files
------------

// File: rtl/adc_serial_stream_gen.sv
// Multi-channel serial ADC stream generator: frame clock plus one MSB-first lane per channel.
// Samples are ramp, constant, alternating or external; start/stop and mode changes are frame-aligned.
module adc_serial_stream_gen #(
    parameter int g_NUM_CH         = 4,
    parameter int g_SAMPLE_WIDTH   = 14,
    parameter int g_BITS_PER_FRAME = 16,
    parameter int g_RAMP_STEP_CH   = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               enable_i,
    input  logic [1:0]                         mode_i,
    input  logic [g_SAMPLE_WIDTH-1:0]          pattern_i,
    input  logic [g_NUM_CH*g_SAMPLE_WIDTH-1:0] ext_data_i,
    input  logic                               ext_valid_i,
    output logic                               ext_ready_o,
    output logic                               fr_o,
    output logic [g_NUM_CH-1:0]                data_o,
    output logic                               busy_o,
    output logic [31:0]                        frame_cnt_o,
    output logic [15:0]                        underflow_cnt_o
);
    localparam int W  = g_SAMPLE_WIDTH;
    localparam int F  = g_BITS_PER_FRAME;
    localparam int CW = $clog2(F);
    localparam logic [CW-1:0] LAST_BIT = CW'(F - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(F / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          rst_sync_reg;
    logic [CW-1:0]       bit_cnt_reg;
    logic [W-1:0]        base_reg;
    logic                phase_reg;
    logic [31:0]         frame_cnt_reg;
    logic [15:0]         underflow_cnt_reg;
    logic [g_NUM_CH-1:0] lane_msb;
    logic                load, start, ext_load, ext_miss;

    // Reset asserts asynchronously but loads are held off until release has been synchronised.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_reg <= 2'b00;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end

    assign load     = rst_sync_reg[1] &&
                      ((state_reg == IDLE && enable_i) || (state_reg == RUN && bit_cnt_reg == LAST_BIT));
    assign start    = load && enable_i;
    assign ext_load = start && (mode_i == 2'd3);
    assign ext_miss = ext_load && !ext_valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (load) state_next = enable_i ? RUN : IDLE;
    end

    always_comb begin
        fr_o        = 1'b0;
        busy_o      = 1'b0;
        data_o      = '0;
        ext_ready_o = ext_load;
        if (state_reg == RUN) begin
            busy_o = 1'b1;
            fr_o   = (bit_cnt_reg < HALF_BIT);
            data_o = lane_msb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_reg       <= '0;
            base_reg          <= '0;
            phase_reg         <= 1'b0;
            frame_cnt_reg     <= '0;
            underflow_cnt_reg <= '0;
        end else begin
            bit_cnt_reg <= (state_reg == RUN && bit_cnt_reg != LAST_BIT) ? bit_cnt_reg + CW'(1) : '0;
            if (start && mode_i == 2'd0) base_reg <= base_reg + W'(1);
            // Alternation restarts on the true pattern whenever a frame of another mode or a stop intervenes.
            if (load) phase_reg <= (start && mode_i == 2'd2) ? ~phase_reg : 1'b0;
            if (start) frame_cnt_reg <= frame_cnt_reg + 32'd1;
            if (ext_miss && underflow_cnt_reg != 16'hFFFF)
                underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt_o     = frame_cnt_reg;
    assign underflow_cnt_o = underflow_cnt_reg;

    generate
        for (genvar gi = 0; gi < g_NUM_CH; gi++) begin : g_lane
            localparam logic [31:0] RAMP_OFS = 32'(gi * g_RAMP_STEP_CH);
            logic [W-1:0] sample;
            logic [W-1:0] shift_reg;
            logic [W-1:0] last_ext_reg;

            always_comb begin
                case (mode_i)
                    2'd0:    sample = base_reg + RAMP_OFS[W-1:0];
                    2'd1:    sample = pattern_i;
                    2'd2:    sample = phase_reg ? ~pattern_i : pattern_i;
                    default: sample = ext_valid_i ? ext_data_i[gi*W +: W] : last_ext_reg;
                endcase
            end

            // Left shift feeds zeros, which provides the LSB padding once the sample is exhausted.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    shift_reg    <= '0;
                    last_ext_reg <= '0;
                end else begin
                    shift_reg <= start ? sample : (shift_reg << 1);
                    if (ext_load && ext_valid_i) last_ext_reg <= ext_data_i[gi*W +: W];
                end
            end

            assign lane_msb[gi] = shift_reg[W-1];
        end
    endgenerate
endmodule

// File: tb/tb_adc_serial_stream_gen.sv
// Directed bench for adc_serial_stream_gen with default parameters (4 lanes, 14-bit samples, 16-bit frames).
module tb_adc_serial_stream_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [13:0] pattern;
    logic [55:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic        fr;
    logic [3:0]  data;
    logic        busy;
    logic [31:0] frame_cnt;
    logic [15:0] underflow_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    adc_serial_stream_gen dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .enable_i        (enable),
        .mode_i          (mode),
        .pattern_i       (pattern),
        .ext_data_i      (ext_data),
        .ext_valid_i     (ext_valid),
        .ext_ready_o     (ext_ready),
        .fr_o            (fr),
        .data_o          (data),
        .busy_o          (busy),
        .frame_cnt_o     (frame_cnt),
        .underflow_cnt_o (underflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Collects one full frame starting at bit 0 and compares lanes, frame clock, ready and busy.
    task automatic capture(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [15:0] e_rdy);
        logic [15:0] w0, w1, w2, w3, wf, wr, wb;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0; wf = '0; wr = '0; wb = '0;
        for (int i = 0; i < 16; i++) begin
            w0 = {w0[14:0], data[0]};
            w1 = {w1[14:0], data[1]};
            w2 = {w2[14:0], data[2]};
            w3 = {w3[14:0], data[3]};
            wf = {wf[14:0], fr};
            wr = {wr[14:0], ext_ready};
            wb = {wb[14:0], busy};
            step();
        end
        check({tag, "_ch0"}, 32'(w0), 32'(e0));
        check({tag, "_ch1"}, 32'(w1), 32'(e1));
        check({tag, "_ch2"}, 32'(w2), 32'(e2));
        check({tag, "_ch3"}, 32'(w3), 32'(e3));
        check({tag, "_fr"},  32'(wf), 32'h0000_FF00);
        check({tag, "_rdy"}, 32'(wr), 32'(e_rdy));
        check({tag, "_busy"}, 32'(wb), 32'h0000_FFFF);
        $display("[TB] frame %s lanes %h %h %h %h fr %h rdy %h", tag, w0, w1, w2, w3, wf, wr);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; pattern = '0; ext_data = '0; ext_valid = 1'b0;
        step(); step();
        check("rst_fr", 32'(fr), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);
        check("rst_underflow", 32'(underflow_cnt), 32'd0);
        check("rst_ready", 32'(ext_ready), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_busy", 32'(busy), 32'd0);

        // Constant 14'h2A5B padded to 16 bits is 16'hA96C.
        enable = 1'b1; mode = 2'd1; pattern = 14'h2A5B;
        step();
        check("first_frame_cnt", frame_cnt, 32'd1);
        check("first_msb", 32'(data), 32'hF);
        capture("A_const", 16'hA96C, 16'hA96C, 16'hA96C, 16'hA96C, 16'h0000);
        mode = 2'd0;
        capture("B_const", 16'hA96C, 16'hA96C, 16'hA96C, 16'hA96C, 16'h0000);
        capture("C_ramp0", 16'h0000, 16'h0400, 16'h0800, 16'h0C00, 16'h0000);
        capture("D_ramp1", 16'h0004, 16'h0404, 16'h0804, 16'h0C04, 16'h0000);
        mode = 2'd2; pattern = 14'h3FFF;
        capture("E_ramp2", 16'h0008, 16'h0408, 16'h0808, 16'h0C08, 16'h0000);
        capture("F_alt_p", 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'h0000);
        capture("G_alt_n", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        mode = 2'd1; pattern = 14'h0F0F;
        capture("H_alt_p", 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'h0000);
        mode = 2'd2; pattern = 14'h3FFF;
        capture("I_const", 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0000);
        capture("J_alt_restart", 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'h0000);

        mode = 2'd3; ext_valid = 1'b1;
        ext_data = {14'h0004, 14'h0003, 14'h0002, 14'h0001};
        capture("K_alt_n", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
        ext_data = {14'h1237, 14'h1236, 14'h1235, 14'h1234};
        capture("L_ext1", 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0001);
        ext_valid = 1'b0; ext_data = '1;
        capture("M_ext2", 16'h48D0, 16'h48D4, 16'h48D8, 16'h48DC, 16'h0001);
        check("underflow_after_miss", 32'(underflow_cnt), 32'd1);
        mode = 2'd1; pattern = 14'h2A5B;
        capture("N_ext_repeat", 16'h48D0, 16'h48D4, 16'h48D8, 16'h48DC, 16'h0000);
        check("underflow_hold", 32'(underflow_cnt), 32'd1);
        check("frame_cnt_15", frame_cnt, 32'd15);

        // Frame-aligned stop: drop enable at bit 5, frame runs through bit 15.
        repeat (5) step();
        enable = 1'b0;
        repeat (10) step();
        check("stop_bit15_busy", 32'(busy), 32'd1);
        check("stop_bit15_fr", 32'(fr), 32'd0);
        step();
        check("stopped_busy", 32'(busy), 32'd0);
        check("stopped_fr", 32'(fr), 32'd0);
        check("stopped_data", 32'(data), 32'd0);
        step();
        check("stopped_frame_cnt", frame_cnt, 32'd15);
        $display("[TB] stop complete frame_cnt %0d", frame_cnt);

        enable = 1'b1;
        step();
        check("restart_msb", 32'(data), 32'hF);
        check("restart_fr", 32'(fr), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_frame_cnt", frame_cnt, 32'd16);

        // Asynchronous reset at bit 9, where the constant pattern drives 1 on every lane.
        repeat (9) step();
        check("pre_rst_data", 32'(data), 32'hF);
        mode = 2'd3;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(data), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_frame_cnt", frame_cnt, 32'd0);
        check("async_rst_underflow", 32'(underflow_cnt), 32'd0);
        check("async_rst_ready", 32'(ext_ready), 32'd0);
        $display("[TB] async reset data %h busy %b frame_cnt %0d", data, busy, frame_cnt);
        step();
        enable = 1'b0; mode = 2'd0;
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        step();
        check("post_rst_frame_cnt", frame_cnt, 32'd1);
        capture("R_ramp_restart", 16'h0000, 16'h0400, 16'h0800, 16'h0C00, 16'h0000);
        capture("S_ramp1", 16'h0004, 16'h0404, 16'h0804, 16'h0C04, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
